// File: rtl/sfp_frame_tx.sv
// sfp_frame_tx: test-frame transmitter for the SFP link test path.
//
// On an accepted start the block emits N_HEADER header words, PAYLOAD_LEN
// incrementing payload words (seed, seed+1, ...) and one checksum trailer
// (modular sum of the payload words). It then holds tx_valid low for GAP_LEN
// cycles so the receiver sees a clean falling edge between frames.
//
// Optional build macro SFP_TX_FRAMENUM_EN: inserts one frame-number word
// (frame_cnt at frame start, zero-extended) between header and payload. That
// word is excluded from the checksum.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      frame request, sampled only while idle
//   seed       first payload word, latched on accepted start
//   tx_data    transmitted word (IDLE_WORD when tx_valid=0), registered
//   tx_valid   high for every frame word, registered
//   busy       high from the cycle after accepted start until back in idle
//   done       one-cycle pulse on the first gap cycle
//   frame_cnt  completed-frame counter, wraps at 16 bits

module sfp_frame_tx #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       N_HEADER    = 6,
    parameter logic [DATA_W-1:0] HEADER_WORD = 16'hBCBC,
    parameter logic [DATA_W-1:0] IDLE_WORD   = 16'h0000,
    parameter int unsigned       PAYLOAD_LEN = 64,
    parameter int unsigned       GAP_LEN     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned CNT_MAX_HP = (N_HEADER > PAYLOAD_LEN) ? N_HEADER : PAYLOAD_LEN;
    localparam int unsigned CNT_MAX    = (CNT_MAX_HP > GAP_LEN) ? CNT_MAX_HP : GAP_LEN;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

    // Terminal counts: the counter holds the index of the word on the output.
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(N_HEADER - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StFnum,
        StPayload,
        StTrailer,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0] next_word;

    assign next_word = word_q + DATA_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            seed_q      <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            tx_data_q   <= IDLE_WORD;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Outputs are registered: each branch computes the word that appears on
    // tx_data during the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        word_d      = word_q;
        csum_d      = csum_q;
        tx_data_d   = IDLE_WORD;
        tx_valid_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d    = StHeader;
                    cnt_d      = '0;
                    seed_d     = seed;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HEADER_WORD;
                    busy_d     = 1'b1;
                end
            end
            StHeader: begin
                tx_valid_d = 1'b1;
                if (cnt_q == HDR_LAST) begin
                    cnt_d = '0;
`ifdef SFP_TX_FRAMENUM_EN
                    state_d   = StFnum;
                    tx_data_d = DATA_W'(frame_cnt_q);
`else
                    state_d   = StPayload;
                    tx_data_d = seed_q;
                    word_d    = seed_q;
                    csum_d    = seed_q;
`endif
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    tx_data_d = HEADER_WORD;
                end
            end
            StFnum: begin
                state_d    = StPayload;
                tx_valid_d = 1'b1;
                tx_data_d  = seed_q;
                word_d     = seed_q;
                csum_d     = seed_q;
            end
            StPayload: begin
                tx_valid_d = 1'b1;
                if (cnt_q == PAY_LAST) begin
                    // csum_q already includes the last payload word.
                    state_d   = StTrailer;
                    cnt_d     = '0;
                    tx_data_d = csum_q;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    word_d    = next_word;
                    csum_d    = csum_q + next_word;
                    tx_data_d = next_word;
                end
            end
            StTrailer: begin
                state_d     = StGap;
                cnt_d       = '0;
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sfp_frame_tx.sv
module tb_sfp_frame_tx;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned N_HEADER    = 6;
    localparam logic [15:0] HEADER_WORD = 16'hBCBC;
    localparam logic [15:0] IDLE_WORD   = 16'h0000;
    localparam int unsigned PAYLOAD_LEN = 64;
    localparam int unsigned GAP_LEN     = 2;
`ifdef SFP_TX_FRAMENUM_EN
    localparam int FN = 1;
`else
    localparam int FN = 0;
`endif
    localparam int P0      = N_HEADER + FN;        // index of first payload word
    localparam int FLEN    = P0 + PAYLOAD_LEN + 1; // valid words per frame
    localparam int LASTIDX = FLEN - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    sfp_frame_tx #(
        .DATA_W     (DATA_W),
        .N_HEADER   (N_HEADER),
        .HEADER_WORD(HEADER_WORD),
        .IDLE_WORD  (IDLE_WORD),
        .PAYLOAD_LEN(PAYLOAD_LEN),
        .GAP_LEN    (GAP_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .seed     (seed),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .done     (done),
        .frame_cnt(frame_cnt)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one expected output record per upcoming cycle; empty queue = idle.
    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        b;
        logic        dn;
        logic [15:0] fc;
    } rec_t;

    rec_t        q[$];
    logic [15:0] m_fcnt = 16'h0000;

    function automatic void push_frame(input logic [15:0] s, input logic [15:0] fc);
        logic [15:0] sum;
        logic [15:0] w;
        sum = 16'h0000;
        for (int i = 0; i < int'(N_HEADER); i++) q.push_back({1'b1, HEADER_WORD, 1'b1, 1'b0, fc});
`ifdef SFP_TX_FRAMENUM_EN
        q.push_back({1'b1, fc, 1'b1, 1'b0, fc});
`endif
        for (int i = 0; i < int'(PAYLOAD_LEN); i++) begin
            w   = s + 16'(i);
            sum = sum + w;
            q.push_back({1'b1, w, 1'b1, 1'b0, fc});
        end
        q.push_back({1'b1, sum, 1'b1, 1'b0, fc});
        for (int g = 0; g < int'(GAP_LEN); g++)
            q.push_back({1'b0, IDLE_WORD, 1'b1, (g == 0), fc + 16'd1});
    endfunction

    function automatic rec_t cur_exp();
        if (q.size() > 0) return q[0];
        return {1'b0, IDLE_WORD, 1'b0, 1'b0, m_fcnt};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_fcnt <= 16'h0000;
        end else if (q.size() == 0) begin
            if (start) begin
                push_frame(seed, m_fcnt);
                m_fcnt <= m_fcnt + 16'd1;
            end
        end else begin
            void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_valid", 32'(tx_valid), 32'(cur_exp().v));
            check("tx_data", 32'(tx_data), 32'(cur_exp().d));
            check("busy", 32'(busy), 32'(cur_exp().b));
            check("done", 32'(done), 32'(cur_exp().dn));
            check("frame_cnt", 32'(frame_cnt), 32'(cur_exp().fc));
        end
    end

    logic [15:0] cap[0:127];
    int          cap_n;

    task automatic wait_idle();
        for (int c = 0; c < 200 && busy; c++) @(negedge clk);
        check("idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic capture_frame(input logic [15:0] s);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
        cap_n = 0;
        for (int c = 0; c < 200; c++) begin
            if (tx_valid) begin
                if (cap_n < 128) cap[cap_n] = tx_data;
                cap_n++;
            end else if (cap_n > 0) begin
                break;
            end
            @(negedge clk);
        end
        wait_idle();
    endtask

    initial begin
        logic [15:0] fc0;
        int          low;
        bit          seen;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(tx_valid), 32'h0);
        check("rst_data", 32'(tx_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_fcnt", 32'(frame_cnt), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Basic frame, seed 0x0010
        capture_frame(16'h0010);
        check("f1_len", 32'(cap_n), 32'(FLEN));
        check("f1_hdr0", 32'(cap[0]), 32'hBCBC);
        check("f1_hdr5", 32'(cap[5]), 32'hBCBC);
        check("f1_pay0", 32'(cap[P0]), 32'h0010);
        check("f1_paylast", 32'(cap[LASTIDX-1]), 32'h004F);
        check("f1_trailer", 32'(cap[LASTIDX]), 32'h0BE0);
        check("f1_fcnt", 32'(frame_cnt), 32'h1);

        // Payload wrap, seed 0xFFF0
        capture_frame(16'hFFF0);
        check("f2_pay15", 32'(cap[P0+15]), 32'hFFFF);
        check("f2_pay16", 32'(cap[P0+16]), 32'h0000);
        check("f2_trailer", 32'(cap[LASTIDX]), 32'h03E0);
        check("f2_fcnt", 32'(frame_cnt), 32'h2);

        // start held: back-to-back frames, 3 low cycles between them
        fc0   = frame_cnt;
        low   = 0;
        seen  = 1'b0;
        start = 1'b1;
        seed  = 16'h1234;
        for (int c = 0; c < 400; c++) begin
            if (frame_cnt == fc0 + 16'd3) break;
            if (tx_valid) begin
                if (low > 0 && seen) check("b2b_gap", 32'(low), 32'd3);
                seen = 1'b1;
                low  = 0;
            end else begin
                low++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        check("b2b_fcnt", 32'(frame_cnt), 32'(fc0 + 16'd3));

        // start during payload is ignored
        fc0   = frame_cnt;
        start = 1'b1;
        seed  = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        seed  = 16'hAAAA;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("ign_fcnt", 32'(frame_cnt), 32'(fc0 + 16'd1));
        check("ign_valid", 32'(tx_valid), 32'h0);

        // Asynchronous reset mid-payload
        start = 1'b1;
        seed  = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(tx_valid), 32'h0);
        check("arst_data", 32'(tx_data), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_fcnt", 32'(frame_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        capture_frame(16'h0000);
        check("r1_len", 32'(cap_n), 32'(FLEN));
        check("r1_trailer", 32'(cap[LASTIDX]), 32'h07E0);
        capture_frame(16'h0000);
`ifdef SFP_TX_FRAMENUM_EN
        check("r2_fnum", 32'(cap[N_HEADER]), 32'h0001);
`endif
        check("r2_len", 32'(cap_n), 32'(FLEN));
        check("r2_trailer", 32'(cap[LASTIDX]), 32'h07E0);
        check("r2_fcnt", 32'(frame_cnt), 32'h2);

        // Randomized starts/seeds with one asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            seed  = 16'($urandom);
            if (c == 1500) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
